// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: thread count, widths, PC step and the
// fetch scheduler state encoding.
package cpu_pkg;
  localparam int unsigned NTHREADS = 4;
  localparam int unsigned THREAD_W = 2;
  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin thread picker: starting one past the pointer, returns the first
// requesting thread. Purely combinational.
module rr_arbiter
  import cpu_pkg::*;
(
  input  logic [NTHREADS-1:0] req,
  input  logic [THREAD_W-1:0] ptr,
  output logic [THREAD_W-1:0] gnt,
  output logic                gnt_valid
);

  // Search ptr+1 .. ptr+NTHREADS (wrapping) and keep the first hit.
  always_comb begin
    logic [THREAD_W-1:0] idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= int'(NTHREADS); i++) begin
      idx = ptr + THREAD_W'(i);
      if (!gnt_valid && req[idx]) begin
        gnt       = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_sched.sv
// Per-thread PC sequencer in front of FETCH. Issues one request at a time,
// round-robin over runnable threads, and hands returned words to decode
// through a single valid/ready slot. Redirects overwrite a thread's PC and
// squash any in-flight or buffered work belonging to that thread.
module fetch_sched
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                redir_valid,
  input  logic [THREAD_W-1:0] redir_thread,
  input  logic [XLEN-1:0]     redir_pc,
  output logic                f_enable,
  output logic                write_mode,
  output logic [XLEN-1:0]     addr,
  output logic [XLEN-1:0]     data_i,
  output logic [THREAD_W-1:0] thread,
  input  logic [XLEN-1:0]     f_data,
  input  logic                ack,
  output logic                ins_valid,
  output logic [XLEN-1:0]     ins_data,
  output logic [THREAD_W-1:0] ins_thread,
  output logic [XLEN-1:0]     ins_pc,
  input  logic                ins_ready
);

  fetch_state_t        state, state_n;
  logic [XLEN-1:0]     pc   [NTHREADS];
  logic [XLEN-1:0]     pc_n [NTHREADS];
  logic [THREAD_W-1:0] ptr, ptr_n;
  logic                stale, stale_n;
  logic                f_enable_n;
  logic [XLEN-1:0]     addr_n;
  logic [THREAD_W-1:0] thread_n;
  logic                ins_valid_n;
  logic [XLEN-1:0]     ins_data_n;
  logic [THREAD_W-1:0] ins_thread_n;
  logic [XLEN-1:0]     ins_pc_n;

  logic [THREAD_W-1:0] gnt;
  logic                gnt_valid;
  logic                redir_hits_req;
  logic                redir_hits_slot;

  // The scheduler never writes memory.
  assign write_mode = 1'b0;
  assign data_i     = '0;

  assign redir_hits_req  = redir_valid && (redir_thread == thread);
  assign redir_hits_slot = redir_valid && (redir_thread == ins_thread);

  rr_arbiter u_arb (
    .req       (thread_en),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Next-state, request port, slot and PC array updates.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ptr_n        = ptr;
    stale_n      = stale;
    f_enable_n   = f_enable;
    addr_n       = addr;
    thread_n     = thread;
    ins_valid_n  = ins_valid;
    ins_data_n   = ins_data;
    ins_thread_n = ins_thread;
    ins_pc_n     = ins_pc;

    // Slot empties when decode takes it, or when its thread is redirected.
    if (ins_valid && (ins_ready || redir_hits_slot)) begin
      ins_valid_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if ((!ins_valid || ins_ready) && gnt_valid) begin
          f_enable_n = 1'b1;
          addr_n     = pc[gnt];
          thread_n   = gnt;
          ptr_n      = gnt;
          state_n    = ST_REQ;
        end
      end
      ST_REQ: begin
        // FETCH cannot abort, so a redirect only marks the word for discard.
        if (redir_hits_req) begin
          stale_n = 1'b1;
        end
        if (ack) begin
          f_enable_n = 1'b0;
          stale_n    = 1'b0;
          state_n    = ST_IDLE;
          if (!stale && !redir_hits_req) begin
            ins_valid_n    = 1'b1;
            ins_data_n     = f_data;
            ins_thread_n   = thread;
            ins_pc_n       = addr;
            pc_n[thread]   = pc[thread] + PC_STEP;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Redirect is applied last so it wins over the post-fetch increment.
    if (redir_valid) begin
      pc_n[redir_thread] = {redir_pc[XLEN-1:2], 2'b00};
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= THREAD_W'(NTHREADS - 1);
      stale      <= 1'b0;
      f_enable   <= 1'b0;
      addr       <= '0;
      thread     <= '0;
      ins_valid  <= 1'b0;
      ins_data   <= '0;
      ins_thread <= '0;
      ins_pc     <= '0;
      for (int i = 0; i < int'(NTHREADS); i++) begin
        pc[i] <= PC_RESET;
      end
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      stale      <= stale_n;
      f_enable   <= f_enable_n;
      addr       <= addr_n;
      thread     <= thread_n;
      ins_valid  <= ins_valid_n;
      ins_data   <= ins_data_n;
      ins_thread <= ins_thread_n;
      ins_pc     <= ins_pc_n;
      pc         <= pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: FETCH responder driven by tasks, plus a
// second instance with PC_RESET at the top of memory and an auto-acking
// responder for the wrap case.
module tb_fetch_sched;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  thread_en = 4'b0000;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_thread = 2'd0;
  logic [31:0] redir_pc = 32'h0;
  logic        f_enable, write_mode;
  logic [31:0] addr, data_i;
  logic [1:0]  thread;
  logic [31:0] f_data = 32'h0;
  logic        ack = 1'b0;
  logic        ins_valid;
  logic [31:0] ins_data, ins_pc;
  logic [1:0]  ins_thread;
  logic        ins_ready = 1'b1;

  logic        f_enable_w, write_mode_w, ins_valid_w, ack_w;
  logic [31:0] addr_w, data_i_w, ins_data_w, ins_pc_w;
  logic [1:0]  thread_w, ins_thread_w;

  fetch_sched #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .thread_en(thread_en),
    .redir_valid(redir_valid), .redir_thread(redir_thread), .redir_pc(redir_pc),
    .f_enable(f_enable), .write_mode(write_mode), .addr(addr), .data_i(data_i),
    .thread(thread), .f_data(f_data), .ack(ack),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_thread(ins_thread),
    .ins_pc(ins_pc), .ins_ready(ins_ready)
  );

  fetch_sched #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .thread_en(4'b0001),
    .redir_valid(1'b0), .redir_thread(2'd0), .redir_pc(32'h0),
    .f_enable(f_enable_w), .write_mode(write_mode_w), .addr(addr_w), .data_i(data_i_w),
    .thread(thread_w), .f_data(32'h1234_5678), .ack(ack_w),
    .ins_valid(ins_valid_w), .ins_data(ins_data_w), .ins_thread(ins_thread_w),
    .ins_pc(ins_pc_w), .ins_ready(1'b1)
  );

  // One-cycle-latency responder for the wrap instance.
  always_ff @(posedge clk) begin
    if (rst) ack_w <= 1'b0;
    else     ack_w <= f_enable_w & ~ack_w;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!f_enable && n < 40) begin
      step();
      n++;
    end
    if (!f_enable) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Hold for lat-1 cycles checking the request stays put, then ack once.
  task automatic finish_req(input int lat, input logic [31:0] data, input logic [31:0] exp_addr);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("hold_en", {31'd0, f_enable}, 32'd1);
      chk("hold_addr", addr, exp_addr);
    end
    ack = 1'b1;
    f_data = data;
    step();
    ack = 1'b0;
    f_data = 32'h0;
  endtask

  logic [1:0]  exp_t [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
  logic [31:0] exp_a [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4};

  initial begin
    int n;
    // Reset state
    do_reset();
    chk("rst_f_enable", {31'd0, f_enable}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_thread", {30'd0, thread}, 32'd0);
    chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_ins_data", ins_data, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h0);
    chk("tie_write_mode", {31'd0, write_mode}, 32'd0);
    chk("tie_data_i", data_i, 32'h0);

    // PC wrap from PC_RESET = FFFF_FFFC
    n = 0;
    while (!f_enable_w && n < 20) begin step(); n++; end
    chk("wrap_first_addr", addr_w, 32'hFFFF_FFFC);
    n = 0;
    while (f_enable_w && n < 20) begin step(); n++; end
    n = 0;
    while (!f_enable_w && n < 20) begin step(); n++; end
    chk("wrap_second_addr", addr_w, 32'h0000_0000);

    // Single thread, ack 2 cycles after each request
    do_reset();
    thread_en = 4'b0001;
    ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req("seq");
      chk("seq_addr", addr, 32'(4 * i));
      chk("seq_thread", {30'd0, thread}, 32'd0);
      finish_req(2, 32'h1, 32'(4 * i));
      chk("seq_ins_valid", {31'd0, ins_valid}, 32'd1);
      chk("seq_f_enable_low", {31'd0, f_enable}, 32'd0);
      chk("seq_ins_pc", ins_pc, 32'(4 * i));
      chk("seq_ins_data", ins_data, 32'h1);
      chk("seq_ins_thread", {30'd0, ins_thread}, 32'd0);
    end

    // Round-robin over 1011 with instant ack
    do_reset();
    thread_en = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_req("rr");
      chk("rr_thread", {30'd0, thread}, {30'd0, exp_t[i]});
      chk("rr_addr", addr, exp_a[i]);
      finish_req(1, 32'hC0DE_0000 + 32'(i), exp_a[i]);
      chk("rr_ins_thread", {30'd0, ins_thread}, {30'd0, exp_t[i]});
      chk("rr_ins_data", ins_data, 32'hC0DE_0000 + 32'(i));
    end

    // Backpressure: no new request while the slot is held
    do_reset();
    thread_en = 4'b0001;
    ins_ready = 1'b0;
    wait_req("bp");
    finish_req(1, 32'hAAAA_0000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_f_enable", {31'd0, f_enable}, 32'd0);
      chk("bp_ins_valid", {31'd0, ins_valid}, 32'd1);
      chk("bp_ins_pc", ins_pc, 32'h0);
    end
    ins_ready = 1'b1;
    step();
    chk("bp_resume_en", {31'd0, f_enable}, 32'd1);
    chk("bp_resume_addr", addr, 32'h4);
    chk("bp_drained", {31'd0, ins_valid}, 32'd0);
    finish_req(1, 32'h0, 32'h4);

    // Redirect against a buffered slot
    do_reset();
    thread_en = 4'b0001;
    ins_ready = 1'b0;
    wait_req("rs");
    finish_req(1, 32'hBBBB_0000, 32'h0);
    redir_valid = 1'b1; redir_thread = 2'd2; redir_pc = 32'h80;
    step();
    redir_valid = 1'b0;
    chk("rs_other_keep", {31'd0, ins_valid}, 32'd1);
    redir_valid = 1'b1; redir_thread = 2'd0; redir_pc = 32'h40;
    step();
    redir_valid = 1'b0;
    chk("rs_own_clear", {31'd0, ins_valid}, 32'd0);
    wait_req("rs2");
    chk("rs_new_addr", addr, 32'h40);
    ins_ready = 1'b1;
    finish_req(1, 32'h5, 32'h40);
    chk("rs_ins_pc", ins_pc, 32'h40);

    // Redirect while request pending (low bits forced to 0)
    do_reset();
    thread_en = 4'b0001;
    wait_req("rp");
    redir_valid = 1'b1; redir_thread = 2'd0; redir_pc = 32'h103;
    step();
    redir_valid = 1'b0;
    chk("rp_hold_en", {31'd0, f_enable}, 32'd1);
    chk("rp_hold_addr", addr, 32'h0);
    finish_req(1, 32'hDEAD_DEAD, 32'h0);
    chk("rp_dropped", {31'd0, ins_valid}, 32'd0);
    wait_req("rp2");
    chk("rp_new_addr", addr, 32'h100);
    finish_req(1, 32'h7, 32'h100);
    chk("rp_kept", {31'd0, ins_valid}, 32'd1);
    chk("rp_ins_pc", ins_pc, 32'h100);

    // Redirect coincident with ack
    wait_req("rc");
    chk("rc_addr", addr, 32'h104);
    redir_valid = 1'b1; redir_thread = 2'd0; redir_pc = 32'h200;
    finish_req(1, 32'hDEAD_BEEF, 32'h104);
    redir_valid = 1'b0;
    chk("rc_dropped", {31'd0, ins_valid}, 32'd0);
    wait_req("rc2");
    chk("rc_new_addr", addr, 32'h200);

    // Redirect of another thread leaves in-flight work alone
    redir_valid = 1'b1; redir_thread = 2'd1; redir_pc = 32'h300;
    finish_req(1, 32'h9, 32'h200);
    redir_valid = 1'b0;
    chk("ro_kept", {31'd0, ins_valid}, 32'd1);
    chk("ro_ins_pc", ins_pc, 32'h200);
    chk("ro_ins_data", ins_data, 32'h9);

    // Reset mid-request, late ack ignored, restart from PC_RESET
    wait_req("rm");
    chk("rm_addr", addr, 32'h204);
    rst = 1'b1;
    step();
    rst = 1'b0;
    thread_en = 4'b0000;
    chk("rm_f_enable", {31'd0, f_enable}, 32'd0);
    ack = 1'b1; f_data = 32'hBAD0_BAD0;
    step();
    ack = 1'b0;
    chk("rm_late_ack", {31'd0, ins_valid}, 32'd0);
    chk("rm_idle", {31'd0, f_enable}, 32'd0);
    thread_en = 4'b0001;
    wait_req("rm2");
    chk("rm_restart_addr", addr, 32'h0);
    finish_req(1, 32'h11, 32'h0);
    chk("rm_restart_pc", ins_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
